// File: rtl/tile_painter.sv
// LCD tile painter: latches one tile request and drives the 8080 write burst (window, RAMWR, pixels).
// Optional LCD power-up sequence compiled in with `PAINTER_INIT_EN`.
module tile_painter #(
    parameter int          TILE_PX     = 15,
    parameter int          INIT_WAIT   = 1200000,
    parameter logic [15:0] COLOR_BG    = 16'h0000,
    parameter logic [15:0] COLOR_BODY  = 16'h07E0,
    parameter logic [15:0] COLOR_HEAD  = 16'hFFE0,
    parameter logic [15:0] COLOR_APPLE = 16'hF800
) (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic       enable,
    input  logic       req,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [1:0] obj_code,
    output logic       cmd_done,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_dc,
    output logic       lcd_wr_n,
    output logic       lcd_cs_n
);
    localparam int          PIX      = TILE_PX * TILE_PX;
    localparam int          PW       = (PIX > 1) ? $clog2(PIX) : 1;
    localparam logic [PW-1:0] PIX_LAST = PW'(PIX - 1);
    localparam logic [15:0] TP       = 16'(TILE_PX);

`ifdef PAINTER_INIT_EN
    localparam logic [1:0]  S_INIT    = 2'd0;
    localparam logic [23:0] WAIT_LAST = 24'(INIT_WAIT - 1);
`endif
    localparam logic [1:0]  S_IDLE = 2'd1;
    localparam logic [1:0]  S_SEND = 2'd2;
    localparam logic [1:0]  S_DONE = 2'd3;

    logic [1:0]    r_state;
    logic [3:0]    r_x, r_y;
    logic [1:0]    r_obj;
    logic [3:0]    r_seq;
    logic          r_lo;
    logic          r_ph;
    logic [PW-1:0] r_pix;

    logic [15:0]   w_xs, w_xe, w_ys, w_ye, w_color;
    logic [3:0]    w_nseq;
    logic [7:0]    w_hdr;
    logic          w_hdr_dc;

    assign w_xs   = 16'(r_x) * TP;
    assign w_xe   = w_xs + TP - 16'd1;
    assign w_ys   = 16'(r_y) * TP;
    assign w_ye   = w_ys + TP - 16'd1;
    assign w_nseq = r_seq + 4'd1;
    assign busy   = (r_state != S_IDLE);

    always_comb begin
        case (r_obj)
            2'b00:   w_color = COLOR_BG;
            2'b01:   w_color = COLOR_BODY;
            2'b10:   w_color = COLOR_HEAD;
            default: w_color = COLOR_APPLE;
        endcase
    end

    // Header byte that follows the one currently on the bus (index 0 is 0x2A, loaded at start).
    always_comb begin
        w_hdr    = 8'h00;
        w_hdr_dc = 1'b1;
        case (w_nseq)
            4'd1:  w_hdr = w_xs[15:8];
            4'd2:  w_hdr = w_xs[7:0];
            4'd3:  w_hdr = w_xe[15:8];
            4'd4:  w_hdr = w_xe[7:0];
            4'd5:  begin w_hdr = 8'h2B; w_hdr_dc = 1'b0; end
            4'd6:  w_hdr = w_ys[15:8];
            4'd7:  w_hdr = w_ys[7:0];
            4'd8:  w_hdr = w_ye[15:8];
            4'd9:  w_hdr = w_ye[7:0];
            4'd10: begin w_hdr = 8'h2C; w_hdr_dc = 1'b0; end
            default: ;
        endcase
    end

`ifdef PAINTER_INIT_EN
    logic [2:0]  r_ist;
    logic [1:0]  r_iph;
    logic [23:0] r_wait;
    logic [7:0]  w_ibyte;
    logic        w_idc;
    logic        w_iwait;

    assign w_iwait = (r_ist == 3'd1) || (r_ist == 3'd3);

    always_comb begin
        w_idc   = 1'b0;
        w_ibyte = 8'h29;
        case (r_ist)
            3'd0:    w_ibyte = 8'h01;
            3'd2:    w_ibyte = 8'h11;
            3'd4:    w_ibyte = 8'h3A;
            3'd5:    begin w_ibyte = 8'h55; w_idc = 1'b1; end
            default: ;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (sync_reset) begin
`ifdef PAINTER_INIT_EN
            r_state <= S_INIT;
            r_ist   <= 3'd0;
            r_iph   <= 2'd0;
            r_wait  <= WAIT_LAST;
`else
            r_state <= S_IDLE;
`endif
            r_x      <= 4'd0;
            r_y      <= 4'd0;
            r_obj    <= 2'd0;
            r_seq    <= 4'd0;
            r_lo     <= 1'b0;
            r_ph     <= 1'b0;
            r_pix    <= '0;
            cmd_done <= 1'b0;
            lcd_data <= 8'h00;
            lcd_dc   <= 1'b1;
            lcd_wr_n <= 1'b1;
            lcd_cs_n <= 1'b1;
        end else begin
            case (r_state)
`ifdef PAINTER_INIT_EN
                S_INIT: begin
                    if (w_iwait) begin
                        if (r_wait == 24'd0) r_ist <= r_ist + 3'd1;
                        else                 r_wait <= r_wait - 24'd1;
                    end else begin
                        case (r_iph)
                            2'd0: begin
                                lcd_data <= w_ibyte;
                                lcd_dc   <= w_idc;
                                lcd_wr_n <= 1'b0;
                                lcd_cs_n <= 1'b0;
                                r_iph    <= 2'd1;
                            end
                            2'd1: begin
                                lcd_wr_n <= 1'b1;
                                r_iph    <= 2'd2;
                            end
                            default: begin
                                lcd_cs_n <= 1'b1;
                                lcd_dc   <= 1'b1;
                                r_iph    <= 2'd0;
                                r_wait   <= WAIT_LAST;
                                if (r_ist == 3'd6) r_state <= S_IDLE;
                                else               r_ist   <= r_ist + 3'd1;
                            end
                        endcase
                    end
                end
`endif
                S_IDLE: begin
                    if (req && enable) begin
                        r_x      <= x;
                        r_y      <= y;
                        r_obj    <= obj_code;
                        r_seq    <= 4'd0;
                        r_ph     <= 1'b0;
                        lcd_data <= 8'h2A;
                        lcd_dc   <= 1'b0;
                        lcd_wr_n <= 1'b0;
                        lcd_cs_n <= 1'b0;
                        r_state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!r_ph) begin
                        lcd_wr_n <= 1'b1;
                        r_ph     <= 1'b1;
                    end else begin
                        r_ph <= 1'b0;
                        if (r_seq < 4'd10) begin
                            r_seq    <= w_nseq;
                            lcd_data <= w_hdr;
                            lcd_dc   <= w_hdr_dc;
                            lcd_wr_n <= 1'b0;
                        end else if (r_seq == 4'd10) begin
                            r_seq    <= 4'd11;
                            r_lo     <= 1'b0;
                            r_pix    <= PIX_LAST;
                            lcd_data <= w_color[15:8];
                            lcd_dc   <= 1'b1;
                            lcd_wr_n <= 1'b0;
                        end else if (!r_lo) begin
                            r_lo     <= 1'b1;
                            lcd_data <= w_color[7:0];
                            lcd_wr_n <= 1'b0;
                        end else if (r_pix == '0) begin
                            cmd_done <= 1'b1;
                            lcd_cs_n <= 1'b1;
                            lcd_dc   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_pix    <= r_pix - PW'(1);
                            r_lo     <= 1'b0;
                            lcd_data <= w_color[15:8];
                            lcd_wr_n <= 1'b0;
                        end
                    end
                end
                default: begin
                    cmd_done <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tile_painter.sv
// Directed bench for tile_painter: byte scoreboard on every write strobe plus cmd_done timing checks.
module tb_tile_painter;
    logic       clk = 1'b0;
    logic       sync_reset = 1'b1;
    logic       enable = 1'b0;
    logic       req = 1'b0;
    logic [3:0] x = 4'd0;
    logic [3:0] y = 4'd0;
    logic [1:0] obj_code = 2'd0;
    logic       cmd_done, busy, lcd_dc, lcd_wr_n, lcd_cs_n;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    tile_painter #(.INIT_WAIT(10)) dut (
        .clk(clk), .sync_reset(sync_reset), .enable(enable), .req(req),
        .x(x), .y(y), .obj_code(obj_code), .cmd_done(cmd_done), .busy(busy),
        .lcd_data(lcd_data), .lcd_dc(lcd_dc), .lcd_wr_n(lcd_wr_n), .lcd_cs_n(lcd_cs_n)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_bytes = 0;
    int n_done = 0;
    logic [8:0] exp_q[$];

`ifdef PAINTER_INIT_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] color_of(input int oc);
        case (oc)
            0: return 16'h0000;
            1: return 16'h07E0;
            2: return 16'hFFE0;
            default: return 16'hF800;
        endcase
    endfunction

    function automatic void push_tile(input int xx, input int yy, input int oc);
        logic [15:0] xs, xe, ys, ye, col;
        xs  = 16'(xx * 15);
        xe  = xs + 16'd14;
        ys  = 16'(yy * 15);
        ye  = ys + 16'd14;
        col = color_of(oc);
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, xs[15:8]}); exp_q.push_back({1'b1, xs[7:0]});
        exp_q.push_back({1'b1, xe[15:8]}); exp_q.push_back({1'b1, xe[7:0]});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, ys[15:8]}); exp_q.push_back({1'b1, ys[7:0]});
        exp_q.push_back({1'b1, ye[15:8]}); exp_q.push_back({1'b1, ye[7:0]});
        exp_q.push_back({1'b0, 8'h2C});
        for (int i = 0; i < 225; i++) begin
            exp_q.push_back({1'b1, col[15:8]});
            exp_q.push_back({1'b1, col[7:0]});
        end
    endfunction

    // Each write strobe low cycle carries one byte; compare it against the scoreboard head.
    always @(negedge clk) begin
        if (lcd_wr_n === 1'b0) begin
            n_bytes++;
            chk("cs_during_byte", 32'(lcd_cs_n), 32'd0);
            if (exp_q.size() == 0) chk("unexpected_byte", 32'({lcd_dc, lcd_data}), 32'hDEAD);
            else chk("byte", 32'({lcd_dc, lcd_data}), 32'(exp_q.pop_front()));
        end
        if (cmd_done === 1'b1) n_done++;
    end

    task automatic start(input int xx, input int yy, input int oc, output int t0);
        @(negedge clk);
        x = 4'(xx); y = 4'(yy); obj_code = 2'(oc);
        req = 1'b1; enable = 1'b1;
        t0 = cyc;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int td);
        td = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cmd_done === 1'b1) begin
                td = cyc;
                break;
            end
        end
        if (td < 0) chk({tag, "_timeout"}, 32'(cmd_done), 32'd1);
    endtask

    task automatic run_init();
`ifdef PAINTER_INIT_EN
        int nd;
        nd = n_done;
        exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h3A}); exp_q.push_back({1'b1, 8'h55});
        exp_q.push_back({1'b0, 8'h29});
        @(negedge clk); req = 1'b1; enable = 1'b1;
        repeat (3) @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 500 && busy !== 1'b0; i++) @(negedge clk);
        chk("init_busy_fall", 32'(busy), 32'd0);
        chk("init_bytes_left", 32'(exp_q.size()), 32'd0);
        chk("init_no_done", 32'(n_done - nd), 32'd0);
`endif
    endtask

    initial begin
        int t0, td, td2, nb, nd;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_done", 32'(cmd_done), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'd0);
        chk("rst_dc", 32'(lcd_dc), 32'd1);
        chk("rst_wr_n", 32'(lcd_wr_n), 32'd1);
        chk("rst_cs_n", 32'(lcd_cs_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'(BUSY_RST));
        sync_reset = 1'b0;
        run_init();

        // Default tile: apple at (3,5)
        push_tile(3, 5, 3);
        start(3, 5, 3, t0);
        chk("byte0_wr_low", 32'(lcd_wr_n), 32'd0);
        chk("byte0_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("byte0_wr_high", 32'(lcd_wr_n), 32'd1);
        chk("byte0_cs_hold", 32'(lcd_cs_n), 32'd0);
        wait_done("t1", td);
        chk("t1_done_cycle", 32'(td - t0), 32'd923);
        chk("t1_done_cs", 32'(lcd_cs_n), 32'd1);
        chk("t1_done_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_done_pulse", 32'(cmd_done), 32'd0);
        chk("t1_idle_dc", 32'(lcd_dc), 32'd1);
        chk("t1_hold_data", 32'(lcd_data), 32'h00);
        chk("t1_bytes_left", 32'(exp_q.size()), 32'd0);

        // Request with enable low is ignored
        nb = n_bytes;
        req = 1'b1; enable = 1'b0;
        repeat (20) @(negedge clk);
        chk("qual_no_write", 32'(n_bytes - nb), 32'd0);
        chk("qual_busy", 32'(busy), 32'd0);
        req = 1'b0;

        // Window edge (15,15) body, with a dropped request at cycle 100
        nd = n_done;
        push_tile(15, 15, 1);
        start(15, 15, 1, t0);
        repeat (99) @(negedge clk);
        x = 4'd0; y = 4'd0; obj_code = 2'd3; req = 1'b1; enable = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_done("t2", td);
        chk("t2_done_cycle", 32'(td - t0), 32'd923);
        repeat (930) @(negedge clk);
        chk("t2_one_done", 32'(n_done - nd), 32'd1);
        chk("t2_bytes_left", 32'(exp_q.size()), 32'd0);
        chk("t2_idle", 32'(busy), 32'd0);

        // Reset at cycle 400 aborts the transfer
        push_tile(1, 2, 2);
        start(1, 2, 2, t0);
        repeat (399) @(negedge clk);
        nd = n_done;
        sync_reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk("abort_cs_n", 32'(lcd_cs_n), 32'd1);
        chk("abort_wr_n", 32'(lcd_wr_n), 32'd1);
        chk("abort_cmd_done", 32'(cmd_done), 32'd0);
        chk("abort_busy", 32'(busy), 32'(BUSY_RST));
        sync_reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_done", 32'(n_done - nd), 32'd0);
        run_init();
        push_tile(2, 3, 0);
        start(2, 3, 0, t0);
        wait_done("t3", td);
        chk("t3_done_cycle", 32'(td - t0), 32'd923);
        @(negedge clk);
        chk("t3_bytes_left", 32'(exp_q.size()), 32'd0);

        // Back-to-back with req held high
        push_tile(4, 6, 2);
        push_tile(4, 6, 2);
        @(negedge clk);
        x = 4'd4; y = 4'd6; obj_code = 2'd2; req = 1'b1; enable = 1'b1;
        t0 = cyc;
        wait_done("b2b_1", td);
        @(negedge clk);
        @(negedge clk);
        req = 1'b0;
        chk("b2b_second_started", 32'(busy), 32'd1);
        wait_done("b2b_2", td2);
        chk("b2b_first_done", 32'(td - t0), 32'd923);
        chk("b2b_spacing", 32'(td2 - td), 32'd924);
        repeat (3) @(negedge clk);
        chk("b2b_bytes_left", 32'(exp_q.size()), 32'd0);
        chk("b2b_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tile_painter.md
# tile_painter

Display-side responder for the frame tracker's tile stream. On a request it latches one tile coordinate and object code and drives the full 8080-style parallel write to the LCD: column window, page window, memory write, then the tile's pixels. When the last byte has been written it answers with a one-cycle `cmd_done`. It sits between the frame tracker/control FSM pair and the LCD pins, closing the loop that the control FSM waits on.

## Interface

**Parameters**
- `TILE_PX`, 15: tile edge in pixels. `x*TILE_PX + TILE_PX - 1` must be ≤ 65535.
- `INIT_WAIT`, 1200000: wait cycles after reset and sleep-out. Used only with `PAINTER_INIT_EN`. 24-bit counter.
- `COLOR_BG`, 16'h0000: RGB565 colour for `obj_code` 00 (empty).
- `COLOR_BODY`, 16'h07E0: colour for `obj_code` 01 (snake body).
- `COLOR_HEAD`, 16'hFFE0: colour for `obj_code` 10 (snake head).
- `COLOR_APPLE`, 16'hF800: colour for `obj_code` 11 (apple).

**Ports**
- `clk` in 1: single clock. All logic on its rising edge.
- `sync_reset` in 1: synchronous, active-high reset.
- `enable` in 1: request qualifier. Driven by the control FSM's loop enable.
- `req` in 1: tile-changed strobe. Driven by the tracker's `diff`.
- `x` in 4: tile column.
- `y` in 4: tile row.
- `obj_code` in 2: object in the tile.
- `cmd_done` out 1: one-cycle pulse when a tile write has finished.
- `busy` out 1: high while the block is not in IDLE.
- `lcd_data` out 8: parallel data bus.
- `lcd_dc` out 1: 0 = command byte, 1 = data byte.
- `lcd_wr_n` out 1: write strobe. The LCD latches on its rising edge.
- `lcd_cs_n` out 1: chip select, active-low.

## Operation

- **States:** INIT (only with the macro), IDLE, SEND, DONE.
- **Start condition:** in IDLE, `req && enable` sampled high latches `x`, `y` and `obj_code` and moves to SEND. Inputs are not re-sampled until the next IDLE.
- **Requests while busy:** ignored. They are not queued.
- **Window arithmetic** (16 bits): XS = x*TILE_PX, XE = XS+TILE_PX-1. YS and YE are computed the same way from `y`.
- **SEND byte order:**
  - 0x2A (command)
  - XS[15:8], XS[7:0], XE[15:8], XE[7:0] (data)
  - 0x2B (command)
  - YS[15:8], YS[7:0], YE[15:8], YE[7:0] (data)
  - 0x2C (command)
  - TILE_PX² pixels, each colour[15:8] then colour[7:0] (data)
- **Byte count:** B = 11 + 2·TILE_PX²; 461 at the default.
- **Pixel counter:** counts down from TILE_PX²-1. It must be wide enough for TILE_PX² (≥8 bits at the default).
- **After SEND:** SEND → DONE after the last byte. DONE lasts one cycle and returns to IDLE.
- **Reset behaviour:** reset at any point, including mid-SEND, aborts the transfer immediately. No `cmd_done` is produced, and the block goes to INIT (macro on) or IDLE (macro off).
- **Reset values of outputs:** `cmd_done`=0, `lcd_data`=0, `lcd_dc`=1, `lcd_wr_n`=1, `lcd_cs_n`=1, `busy`=1 with the macro / 0 without it.

## Timing

- Cycle 0 is the cycle in which `req && enable` is sampled in IDLE.
- Byte i (0-based) is driven with `lcd_data` and `lcd_dc` stable for cycles 1+2i and 2+2i.
- `lcd_wr_n`=0 in cycle 1+2i and =1 in cycle 2+2i.
- `lcd_cs_n`=0 from cycle 1 through cycle 2B.
- In cycle 2B+1 (DONE): `cmd_done`=1, `lcd_cs_n`=1, `busy`=1. At the default this is cycle 923.
- Cycle 2B+2: IDLE, `busy`=0. The earliest new start is sampled here.
- `busy` is high from cycle 1 through cycle 2B+1.
- Between transfers: `lcd_wr_n`=1, `lcd_dc`=1, `lcd_data` holds its last value.

## Configuration

- **Macro:** `PAINTER_INIT_EN`.
- **Defined:** after reset the block runs INIT, using the same 2-cycle byte timing and `lcd_cs_n` low only during bytes. Sequence:
  1. cmd 0x01
  2. wait INIT_WAIT cycles
  3. cmd 0x11
  4. wait INIT_WAIT cycles
  5. cmd 0x3A, data 0x55
  6. cmd 0x29
  7. go to IDLE
- **Defined, during INIT:** `busy`=1, requests are ignored, and no `cmd_done` is produced.
- **Undefined:** the INIT state and its counter are absent. The block enters IDLE directly out of reset with `busy`=0, and the host owns LCD initialisation.

## Test plan

- **Default tile write, macro off:** reset, then `req`=`enable`=1 with x=3, y=5, obj_code=11.
  - Bytes: 2A,00,2D,00,3B,2B,00,4B,00,59,2C, then 225×(F8,00).
  - `cmd_done` pulses once, in cycle 923.
- **Window wrap edge:** x=15, y=15, obj_code=01.
  - Windows: XS=00E1, XE=00EF; YS and YE the same.
  - Pixels are 07,E0.
- **Qualifier and busy:** `req`=1 with `enable`=0 → no `lcd_wr_n` activity.
  - A second `req` at cycle 100 of a transfer is dropped.
  - Exactly one `cmd_done`, and the latched x/y are unchanged.
- **Reset mid-operation:** assert `sync_reset` at cycle 400 of a transfer.
  - Next cycle: `lcd_cs_n`=1, `lcd_wr_n`=1, `cmd_done`=0.
  - A new request then completes normally.
- **Back-to-back:** `req` held high continuously.
  - Second transfer's cycle 0 is cycle 924 of the first, with `cmd_done` spacing of 924 cycles.
  - `obj_code`=00 → pixels 00,00.
- **Init, macro on, INIT_WAIT=10:** bytes 01, then wait; 11, then wait; 3A,55,29.
  - `busy` falls only after 0x29.
  - A `req` during INIT is ignored.
